// File: rtl/rd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rd_arb_pkg
// Purpose  : Shared widths, AR payload type and arbiter state encoding.
// Revision : 1.0
// ============================================================================
package rd_arb_pkg;

    localparam int ADRW = 40;
    localparam int LENW = 8;
    localparam int DW   = 64;

    typedef struct packed {
        logic [ADRW-1:0] adr;
        logic [LENW-1:0] len;
    } ar_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } ar_state_e;

endpackage
`default_nettype wire

// File: rtl/rd_route_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rd_route_fifo
// Purpose  : Sync FIFO of requester indices, one entry per outstanding burst.
// Revision : 1.0
// ============================================================================
module rd_route_fifo #(
    parameter int W = 2,
    parameter int D = 4
) (
    input  logic                   aclk,
    input  logic                   arst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(D+1)-1:0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(D);
    localparam int CW = $clog2(D+1);

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          w_push, w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // D is a power of two, so the pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(D));
    assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/rd_cache_arb.sv
`default_nettype none
// ============================================================================
// Module   : rd_cache_arb
// Purpose  : Round-robin AXI4 read arbiter; R beats routed back in issue order.
// Revision : 1.0
// ============================================================================
module rd_cache_arb
    import rd_arb_pkg::*;
#(
    parameter int NR     = 4,
    parameter int MAXOUT = 4
) (
    input  logic                        aclk,
    input  logic                        arst_n,
    input  logic [NR*ADRW-1:0]          s_araddr,
    input  logic [NR*LENW-1:0]          s_arlen,
    input  logic [NR-1:0]               s_arvalid,
    output logic [NR-1:0]               s_arready,
    output logic [DW-1:0]               s_rdata,
    output logic [NR-1:0]               s_rvalid,
    output logic [NR-1:0]               s_rlast,
    input  logic [NR-1:0]               s_rready,
    output logic [ADRW-1:0]             m_araddr,
    output logic [LENW-1:0]             m_arlen,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    input  logic [DW-1:0]               m_rdata,
    input  logic                        m_rvalid,
    input  logic                        m_rlast,
    output logic                        m_rready,
    output logic [$clog2(MAXOUT+1)-1:0] outst
);

    localparam int IDW = $clog2(NR);
    localparam int OW  = $clog2(MAXOUT+1);

    ar_state_e      state_q, state_d;
    logic [IDW-1:0] gnt_q, gnt_d;
    logic [IDW-1:0] last_gnt_q, last_gnt_d;
    ar_t            ar_q, ar_d;
    logic           arvalid_q, arvalid_d;

    logic [IDW-1:0] w_pick, w_head;
    logic [OW-1:0]  w_count;
    logic           w_full, w_empty, w_push, w_pop;

    // Rotate so the requester after last grant sits at bit 0, take the lowest
    // set bit, then rotate the index back.
    function automatic logic [IDW-1:0] rr_pick(input logic [NR-1:0]  req,
                                               input logic [IDW-1:0] last);
        logic [2*NR-1:0] dbl;
        logic [NR-1:0]   rot;
        int              sel;
        int              off;
        dbl = {req, req};
        rot = NR'(dbl >> (int'(last) + 1));
        sel = 0;
        for (int i = NR-1; i >= 0; i--) begin
            if (rot[i]) sel = i;
        end
        off = (sel + int'(last) + 1) % NR;
        return IDW'(off);
    endfunction

    assign w_pick = rr_pick(s_arvalid, last_gnt_q);
    assign w_push = (state_q == ST_ISSUE) && m_arready;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        ar_d       = ar_q;
        arvalid_d  = arvalid_q;
        case (state_q)
            ST_IDLE: begin
                // Registered occupancy: a pop this cycle cannot free a slot yet
                if (|s_arvalid && !w_full) begin
                    gnt_d     = w_pick;
                    ar_d.adr  = s_araddr[ADRW*w_pick +: ADRW];
                    ar_d.len  = s_arlen[LENW*w_pick +: LENW];
                    arvalid_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_arready) begin
                    arvalid_d  = 1'b0;
                    last_gnt_d = gnt_q;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            last_gnt_q <= IDW'(NR-1);
            ar_q       <= '0;
            arvalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            ar_q       <= ar_d;
            arvalid_q  <= arvalid_d;
        end
    end

    rd_route_fifo #(
        .W (IDW),
        .D (MAXOUT)
    ) u_route_fifo (
        .aclk      (aclk),
        .arst_n    (arst_n),
        .push      (w_push),
        .push_data (gnt_q),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign m_araddr  = ar_q.adr;
    assign m_arlen   = ar_q.len;
    assign m_arvalid = arvalid_q;
    assign s_arready = w_push ? (NR'(1) << gnt_q) : '0;

    // With no burst outstanding a stray beat is held off and routed nowhere
    assign s_rvalid = w_empty ? '0 : (NR'(m_rvalid) << w_head);
    assign s_rlast  = w_empty ? '0 : (NR'(m_rvalid && m_rlast) << w_head);
    assign m_rready = !w_empty && s_rready[w_head];
    assign w_pop    = m_rvalid && m_rready && m_rlast;
    assign s_rdata  = m_rdata;
    assign outst    = w_count;

endmodule
`default_nettype wire

// File: tb/tb_rd_cache_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rd_cache_arb
// Purpose  : Random traffic against a transaction-level arbiter/route model.
// Revision : 1.0
// ============================================================================
module tb_rd_cache_arb;

    localparam int NR     = 4;
    localparam int MAXOUT = 4;
    localparam int OW     = $clog2(MAXOUT+1);

    logic               aclk = 1'b0;
    logic               arst_n;
    logic [NR*40-1:0]   s_araddr;
    logic [NR*8-1:0]    s_arlen;
    logic [NR-1:0]      s_arvalid;
    logic [NR-1:0]      s_arready;
    logic [63:0]        s_rdata;
    logic [NR-1:0]      s_rvalid;
    logic [NR-1:0]      s_rlast;
    logic [NR-1:0]      s_rready;
    logic [39:0]        m_araddr;
    logic [7:0]         m_arlen;
    logic               m_arvalid;
    logic               m_arready;
    logic [63:0]        m_rdata;
    logic               m_rvalid;
    logic               m_rlast;
    logic               m_rready;
    logic [OW-1:0]      outst;

    rd_cache_arb #(.NR(NR), .MAXOUT(MAXOUT)) dut (
        .aclk      (aclk),
        .arst_n    (arst_n),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rvalid  (s_rvalid),
        .s_rlast   (s_rlast),
        .s_rready  (s_rready),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rvalid  (m_rvalid),
        .m_rlast   (m_rlast),
        .m_rready  (m_rready),
        .outst     (outst)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: an AR in flight (or not) and the ordered list of
    // requesters whose bursts the memory still owes.
    bit          md_busy;
    int          md_gnt;
    int          md_last;
    logic [39:0] md_adr;
    logic [7:0]  md_len;
    int          md_route[$];

    // Requester and memory-side stimulus state
    bit          rq_v [NR];
    logic [39:0] rq_a [NR];
    logic [7:0]  rq_l [NR];
    int          memq[$];
    int          beat;

    int p_req, p_ardy, p_rv, p_rrdy;

    task automatic model_reset();
        md_busy = 1'b0;
        md_gnt  = 0;
        md_last = NR-1;
        md_adr  = '0;
        md_len  = '0;
        md_route.delete();
        for (int i = 0; i < NR; i++) rq_v[i] = 1'b0;
        memq.delete();
        beat = 0;
    endtask

    task automatic run_cycle(input bit do_rst);
        int            sz;
        int            hd;
        logic [NR-1:0] e_arready, e_rvalid, e_rlast;
        logic          e_mrready;
        bit            mem_push, r_hs, pop;
        int            push_len;
        @(negedge aclk);
        arst_n = !do_rst;
        for (int i = 0; i < NR; i++) begin
            if (!rq_v[i] && !do_rst && ($urandom % 100) < p_req) begin
                rq_v[i] = 1'b1;
                rq_a[i] = {8'h0, $urandom} & ~40'h7;
                rq_l[i] = (($urandom % 16) == 0) ? 8'd63 : 8'($urandom % 8);
            end
            s_arvalid[i]      = rq_v[i];
            s_araddr[40*i+:40] = rq_a[i];
            s_arlen[8*i+:8]    = rq_l[i];
            s_rready[i]        = ($urandom % 100) < p_rrdy;
        end
        m_arready = !do_rst && (($urandom % 100) < p_ardy);
        m_rdata   = {$urandom, $urandom};
        if (memq.size() > 0 && !do_rst) begin
            m_rvalid = ($urandom % 100) < p_rv;
            m_rlast  = (beat == memq[0]);
        end else begin
            m_rvalid = !do_rst && (($urandom % 10) == 0);
            m_rlast  = $urandom % 2;
        end
        #1;
        sz        = md_route.size();
        hd        = (sz > 0) ? md_route[0] : 0;
        e_arready = (md_busy && m_arready) ? (NR'(1) << md_gnt) : '0;
        e_rvalid  = (sz > 0 && m_rvalid) ? (NR'(1) << hd) : '0;
        e_rlast   = (sz > 0 && m_rvalid && m_rlast) ? (NR'(1) << hd) : '0;
        e_mrready = (sz > 0) && s_rready[hd];
        if (!do_rst) begin
            check_eq("m_arvalid", 64'(m_arvalid), 64'(md_busy));
            check_eq("m_araddr",  64'(m_araddr),  64'(md_adr));
            check_eq("m_arlen",   64'(m_arlen),   64'(md_len));
            check_eq("outst",     64'(outst),     64'(sz));
            check_eq("s_arready", 64'(s_arready), 64'(e_arready));
            check_eq("s_rvalid",  64'(s_rvalid),  64'(e_rvalid));
            check_eq("s_rlast",   64'(s_rlast),   64'(e_rlast));
            check_eq("m_rready",  64'(m_rready),  64'(e_mrready));
            check_eq("s_rdata",   s_rdata,        m_rdata);
        end
        mem_push = m_arvalid && m_arready;
        push_len = int'(m_arlen);
        r_hs     = m_rvalid && m_rready && (memq.size() > 0);
        @(posedge aclk);
        if (do_rst) begin
            model_reset();
        end else begin
            pop = (sz > 0) && m_rvalid && e_mrready && m_rlast;
            if (md_busy) begin
                if (m_arready) begin
                    md_route.push_back(md_gnt);
                    md_last     = md_gnt;
                    md_busy     = 1'b0;
                    rq_v[md_gnt] = 1'b0;
                end
            end else if (s_arvalid != '0 && sz < MAXOUT) begin
                for (int k = 1; k <= NR; k++) begin
                    if (!md_busy && s_arvalid[(md_last + k) % NR]) begin
                        md_gnt  = (md_last + k) % NR;
                        md_busy = 1'b1;
                    end
                end
                md_adr = rq_a[md_gnt];
                md_len = rq_l[md_gnt];
            end
            if (pop) void'(md_route.pop_front());
            if (r_hs) begin
                if (beat == memq[0]) begin
                    void'(memq.pop_front());
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            if (mem_push) memq.push_back(push_len);
        end
    endtask

    initial begin
        arst_n    = 1'b0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arvalid = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        p_req = 0; p_ardy = 0; p_rv = 0; p_rrdy = 0;
        model_reset();
        repeat (2) run_cycle(1'b1);

        // Fill to MAXOUT with no R data so further grants stall
        p_req = 70; p_ardy = 80; p_rv = 0; p_rrdy = 100;
        repeat (40) run_cycle(1'b0);

        // Heavy bidirectional traffic
        p_rv = 85; p_rrdy = 90;
        repeat (800) run_cycle(1'b0);

        // Back-pressure on both AR and R
        p_ardy = 40; p_rv = 60; p_rrdy = 30;
        repeat (800) run_cycle(1'b0);

        // Build up outstanding bursts, then reset mid-burst
        p_ardy = 90; p_rv = 20; p_rrdy = 50;
        repeat (30) run_cycle(1'b0);
        run_cycle(1'b1);
        p_req = 90; p_rv = 80; p_rrdy = 80;
        repeat (800) run_cycle(1'b0);

        // Saturated requesters, slow memory: round-robin fairness under full load
        p_req = 100; p_ardy = 100; p_rv = 30; p_rrdy = 100;
        repeat (600) run_cycle(1'b0);
        run_cycle(1'b1);
        repeat (50) run_cycle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
